// File: rtl/hw_loc_serializer.sv
// hw_loc_serializer
// Captures one Hamming-weight result (count + packed set-bit locations) per
// input handshake and replays it as a "COUNT LOC0 LOC1 ..." beat stream on a
// valid/ready output. Only the first min(count, MAX_LOC) slots are emitted.
module hw_loc_serializer #(
    parameter int MAX_LOC = 32,
    parameter int LOC_W   = 10,
    parameter int CNT_W   = 11
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CNT_W-1:0]         in_count,
    input  logic [MAX_LOC*LOC_W-1:0] in_loc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CNT_W-1:0]         out_data,
    output logic                     out_is_count,
    output logic                     out_eof,
    output logic                     out_trunc
);

    // n needs to represent MAX_LOC itself; the slot index only 0..MAX_LOC-1
    localparam int N_W = $clog2(MAX_LOC + 1);
    localparam int S_W = (MAX_LOC > 1) ? $clog2(MAX_LOC) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        LOC  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [S_W-1:0]   slot_reg, slot_next;
    logic [N_W-1:0]   n_reg, n_next;
    logic [CNT_W-1:0] count_reg;
    logic [LOC_W-1:0] loc_reg [MAX_LOC];

    logic             capture;
    logic [N_W-1:0]   n_cap;

    // A new result may be taken when idle, or in the very cycle the last beat
    // of the current record is accepted (no bubble between records).
    assign in_ready = (state_reg == IDLE) | (out_valid & out_ready & out_eof);
    assign capture  = in_valid & in_ready;
    assign n_cap    = (in_count > CNT_W'(MAX_LOC)) ? N_W'(MAX_LOC) : in_count[N_W-1:0];

    // FSM state, slot index and emitted-location count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            slot_reg  <= '0;
            n_reg     <= '0;
        end else begin
            state_reg <= state_next;
            slot_reg  <= slot_next;
            n_reg     <= n_next;
        end
    end

    // Captured count; pure datapath, only meaningful once a record is in flight
    always_ff @(posedge clk) begin
        if (capture) begin
            count_reg <= in_count;
        end
    end

    // One register per location slot so a whole result is latched in one cycle
    generate
        for (genvar gi = 0; gi < MAX_LOC; gi++) begin : g_slot
            // Latch slot gi on capture; isolates the record from later input changes
            always_ff @(posedge clk) begin
                if (capture) begin
                    loc_reg[gi] <= in_loc[gi*LOC_W +: LOC_W];
                end
            end
        end
    endgenerate

    // Output decode from registered state only, so out_valid never sees out_ready
    always_comb begin
        out_valid    = 1'b0;
        out_data     = '0;
        out_is_count = 1'b0;
        out_eof      = 1'b0;
        out_trunc    = 1'b0;
        case (state_reg)
            HDR: begin
                out_valid    = 1'b1;
                out_data     = count_reg;
                out_is_count = 1'b1;
                out_trunc    = (count_reg > CNT_W'(MAX_LOC));
                out_eof      = (n_reg == '0);
            end
            LOC: begin
                out_valid = 1'b1;
                out_data  = CNT_W'(loc_reg[slot_reg]);
                out_eof   = (N_W'(slot_reg) == (n_reg - N_W'(1)));
            end
            default: ;
        endcase
    end

    // Next-state: advance on accepted beats, chain straight into a new header on capture
    always_comb begin
        state_next = state_reg;
        slot_next  = slot_reg;
        n_next     = n_reg;
        case (state_reg)
            IDLE: begin
                if (capture) begin
                    state_next = HDR;
                end
            end
            HDR: begin
                if (out_ready) begin
                    if (n_reg != '0) begin
                        state_next = LOC;
                        slot_next  = '0;
                    end else begin
                        state_next = capture ? HDR : IDLE;
                    end
                end
            end
            LOC: begin
                if (out_ready) begin
                    if (out_eof) begin
                        state_next = capture ? HDR : IDLE;
                    end else begin
                        slot_next = slot_reg + S_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (capture) begin
            n_next    = n_cap;
            slot_next = '0;
        end
    end

endmodule

// File: tb/tb_hw_loc_serializer.sv
// Directed testbench for hw_loc_serializer: one task per scenario, inline checks.
module tb_hw_loc_serializer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [10:0]  in_count = '0;
    logic [319:0] in_loc = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [10:0]  out_data;
    logic         out_is_count;
    logic         out_eof;
    logic         out_trunc;

    int total = 0;
    int bad   = 0;

    logic [319:0] loc_buf;
    logic [10:0]  q_data[$];
    bit           q_cnt[$];
    bit           q_eof[$];
    bit           q_trunc[$];
    int           coll_cycles;
    bit           coll_to;
    bit           send_to;

    always #5 clk = ~clk;

    hw_loc_serializer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_count    (in_count),
        .in_loc      (in_loc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_is_count(out_is_count),
        .out_eof     (out_eof),
        .out_trunc   (out_trunc)
    );

    // Offer one result, wait (bounded) for in_ready, then scramble the inputs
    task automatic send(input logic [10:0] cnt, input logic [319:0] loc);
        @(negedge clk);
        in_valid = 1'b1;
        in_count = cnt;
        in_loc   = loc;
        #1;
        send_to = 1'b1;
        for (int w = 0; w < 50; w++) begin
            if (in_ready) begin
                send_to = 1'b0;
                break;
            end
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_count = 11'h7ff;
        in_loc   = ~loc;
    endtask

    // Record accepted beats with out_ready held high until an eof beat
    task automatic collect();
        q_data.delete(); q_cnt.delete(); q_eof.delete(); q_trunc.delete();
        coll_to     = 1'b1;
        coll_cycles = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            #1;
            coll_cycles++;
            if (out_valid && out_ready) begin
                q_data.push_back(out_data);
                q_cnt.push_back(out_is_count);
                q_eof.push_back(out_eof);
                q_trunc.push_back(out_trunc);
                if (out_eof) begin
                    coll_to = 1'b0;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++;
        if (out_valid !== 1'b0 || out_data !== 11'd0 || out_is_count !== 1'b0 ||
            out_eof !== 1'b0 || out_trunc !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%b data=%0d cnt=%b eof=%b trunc=%b, need all 0",
                     out_valid, out_data, out_is_count, out_eof, out_trunc);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b need 1", in_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        $display("test_reset: done");
    endtask

    task automatic test_zero();
        send(11'd0, '0);
        collect();
        total++;
        if (send_to || coll_to || q_data.size() != 1) begin
            bad++;
            $display("FAIL zero_beats: got %0d beats (timeout %b/%b), need 1", q_data.size(), send_to, coll_to);
        end else begin
            total++;
            if (q_data[0] !== 11'd0 || q_cnt[0] !== 1'b1 || q_eof[0] !== 1'b1 || q_trunc[0] !== 1'b0) begin
                bad++;
                $display("FAIL zero_header: got data=%0d cnt=%b eof=%b trunc=%b, need 0 1 1 0",
                         q_data[0], q_cnt[0], q_eof[0], q_trunc[0]);
            end
        end
        @(negedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL zero_idle: got in_ready=%b out_valid=%b, need 1 0", in_ready, out_valid);
        end
        $display("test_zero: %0d beats", q_data.size());
    endtask

    task automatic test_three();
        int exp_d[4] = '{3, 5, 17, 1023};
        for (int k = 0; k < 32; k++) loc_buf[k*10 +: 10] = 10'(900 + k);
        loc_buf[0 +: 10]  = 10'd5;
        loc_buf[10 +: 10] = 10'd17;
        loc_buf[20 +: 10] = 10'd1023;
        send(11'd3, loc_buf);
        collect();
        total++;
        if (send_to || coll_to || q_data.size() != 4 || coll_cycles != 4) begin
            bad++;
            $display("FAIL three_len: got %0d beats in %0d cycles, need 4 in 4", q_data.size(), coll_cycles);
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (q_data[i] !== 11'(exp_d[i]) || q_cnt[i] !== (i == 0) || q_eof[i] !== (i == 3)) begin
                    bad++;
                    $display("FAIL three_beat%0d: got data=%0d cnt=%b eof=%b, need %0d %b %b",
                             i, q_data[i], q_cnt[i], q_eof[i], exp_d[i], i == 0, i == 3);
                end
            end
        end
        $display("test_three: %0d beats", q_data.size());
    endtask

    task automatic test_full_trunc();
        logic [10:0] cnts[2] = '{11'd32, 11'd600};
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 32; k++) loc_buf[k*10 +: 10] = 10'((k * 31 + 7 + r * 100) % 1024);
            send(cnts[r], loc_buf);
            collect();
            total++;
            if (send_to || coll_to || q_data.size() != 33) begin
                bad++;
                $display("FAIL full%0d_len: got %0d beats, need 33", r, q_data.size());
            end else begin
                total++;
                if (q_data[0] !== cnts[r] || q_trunc[0] !== (r == 1) || q_eof[0] !== 1'b0) begin
                    bad++;
                    $display("FAIL full%0d_header: got data=%0d trunc=%b eof=%b, need %0d %b 0",
                             r, q_data[0], q_trunc[0], q_eof[0], cnts[r], r == 1);
                end
                for (int k = 0; k < 32; k++) begin
                    total++;
                    if (q_data[k+1] !== 11'((k * 31 + 7 + r * 100) % 1024) || q_eof[k+1] !== (k == 31)) begin
                        bad++;
                        $display("FAIL full%0d_loc%0d: got %0d eof=%b, need %0d eof=%b",
                                 r, k, q_data[k+1], q_eof[k+1], (k * 31 + 7 + r * 100) % 1024, k == 31);
                    end
                end
            end
        end
        $display("test_full_trunc: done");
    endtask

    task automatic test_backpressure();
        bit          pat[12] = '{0, 1, 0, 0, 1, 0, 1, 1, 1, 1, 1, 1};
        logic [10:0] exp_d[3] = '{11'd2, 11'd100, 11'd200};
        logic [10:0] held_d;
        logic [2:0]  held_f;
        bit          stalled = 1'b0;
        bit          done = 1'b0;
        int          acc = 0;
        for (int k = 0; k < 32; k++) loc_buf[k*10 +: 10] = 10'(300 + k);
        loc_buf[0 +: 10]  = 10'd100;
        loc_buf[10 +: 10] = 10'd200;
        send(11'd2, loc_buf);
        for (int c = 0; c < 12 && !done; c++) begin
            @(negedge clk);
            out_ready = pat[c];
            #1;
            if (stalled) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== held_d || {out_is_count, out_eof, out_trunc} !== held_f) begin
                    bad++;
                    $display("FAIL bp_hold%0d: got valid=%b data=%0d flags=%b, need 1 %0d %b",
                             c, out_valid, out_data, {out_is_count, out_eof, out_trunc}, held_d, held_f);
                end
            end
            total++;
            if (in_ready !== (out_ready && acc == 2)) begin
                bad++;
                $display("FAIL bp_in_ready%0d: got %b need %b", c, in_ready, out_ready && acc == 2);
            end
            if (out_valid && out_ready) begin
                total++;
                if (acc > 2 || out_data !== exp_d[acc] || out_eof !== (acc == 2)) begin
                    bad++;
                    $display("FAIL bp_beat%0d: got data=%0d eof=%b, need %0d %b",
                             acc, out_data, out_eof, exp_d[acc % 3], acc == 2);
                end
                if (out_eof) done = 1'b1;
                acc++;
                stalled = 1'b0;
            end else begin
                stalled = out_valid;
                held_d  = out_data;
                held_f  = {out_is_count, out_eof, out_trunc};
            end
        end
        total++;
        if (!done || acc != 3) begin
            bad++;
            $display("FAIL bp_count: got %0d beats done=%b, need 3", acc, done);
        end
        $display("test_backpressure: %0d beats", acc);
    endtask

    task automatic test_back_to_back();
        logic [10:0] exp_d[5] = '{11'd1, 11'd321, 11'd2, 11'd45, 11'd678};
        bit          exp_c[5] = '{1, 0, 1, 0, 0};
        bit          exp_e[5] = '{0, 1, 0, 0, 1};
        loc_buf = '1;
        loc_buf[0 +: 10] = 10'd321;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_count  = 11'd1;
        in_loc    = loc_buf;
        @(posedge clk);
        #1;
        loc_buf[0 +: 10]  = 10'd45;
        loc_buf[10 +: 10] = 10'd678;
        in_count = 11'd2;
        in_loc   = loc_buf;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 2) in_valid = 1'b0;
            #1;
            total++;
            if (out_valid !== 1'b1 || out_data !== exp_d[c] || out_is_count !== exp_c[c] || out_eof !== exp_e[c]) begin
                bad++;
                $display("FAIL b2b_beat%0d: got valid=%b data=%0d cnt=%b eof=%b, need 1 %0d %b %b",
                         c, out_valid, out_data, out_is_count, out_eof, exp_d[c], exp_c[c], exp_e[c]);
            end
            if (c == 1) begin
                total++;
                if (in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_overlap: got in_ready=%b at first eof, need 1", in_ready);
                end
            end
        end
        @(negedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_idle: got out_valid=%b in_ready=%b, need 0 1", out_valid, in_ready);
        end
        $display("test_back_to_back: done");
    endtask

    task automatic test_reset_mid();
        int  acc = 0;
        bit  hit = 1'b0;
        for (int k = 0; k < 32; k++) loc_buf[k*10 +: 10] = 10'(500 + k);
        send(11'd10, loc_buf);
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            #1;
            if (acc == 5 && out_valid) begin
                hit = 1'b1;
                total++;
                if (out_data !== 11'd504 || out_is_count !== 1'b0) begin
                    bad++;
                    $display("FAIL rst_mid_slot4: got data=%0d cnt=%b, need 504 0", out_data, out_is_count);
                end
                rst_n = 1'b0;
                #1;
                total++;
                if (out_valid !== 1'b0 || out_data !== 11'd0) begin
                    bad++;
                    $display("FAIL rst_mid_async: got valid=%b data=%0d, need 0 0", out_valid, out_data);
                end
            end else if (out_valid && out_ready) begin
                acc++;
            end
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL rst_mid_reach: slot 4 beat not seen after %0d beats", acc);
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL rst_mid_idle: got out_valid=%b in_ready=%b, need 0 1", out_valid, in_ready);
            end
        end
        loc_buf = '0;
        loc_buf[0 +: 10] = 10'd77;
        send(11'd1, loc_buf);
        collect();
        total++;
        if (send_to || coll_to || q_data.size() != 2 || q_data[0] !== 11'd1 || q_cnt[0] !== 1'b1 ||
            q_data[1] !== 11'd77 || q_eof[1] !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_next: got %0d beats first=%0d, need 2 beats 1 77",
                     q_data.size(), (q_data.size() > 0) ? q_data[0] : 11'd0);
        end
        $display("test_reset_mid: done");
    endtask

    initial begin
        test_reset();
        test_zero();
        test_three();
        test_full_trunc();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
